// File: rtl/kgp_risc_pkg.sv
// -----------------------------------------------------------------------------
// kgp_risc_pkg
// Shared definitions for the KGP-RISC ALU datapath blocks.
//   div_state_e   : sequential divider control states (IDLE/RUN/DONE)
//   DIV_ITERS     : number of subtract-and-shift iterations per divide
//   DIV_ZERO_QUOT : quotient reported for a zero divisor
//   abs32()       : two's-complement magnitude (0x8000_0000 maps to itself,
//                   which is the correct unsigned magnitude)
// -----------------------------------------------------------------------------
package kgp_risc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int          DIV_ITERS     = 32;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/subtractor_32_bit.sv
// -----------------------------------------------------------------------------
// subtractor_32_bit
// Combinational a - b, formed as a + ~b + 1. The carry-out is the inverse of
// the borrow: c_out = 1 means a >= b (unsigned).
//   i_a, i_b : operands
//   o_diff   : a - b modulo 2^32
//   o_c_out  : carry out of the addition (borrow = ~o_c_out)
// -----------------------------------------------------------------------------
module subtractor_32_bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_c_out
);

  assign {o_c_out, o_diff} = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/seq_divider_32_bit.sv
// -----------------------------------------------------------------------------
// seq_divider_32_bit
// Iterative restoring divider, one quotient bit per cycle. A start pulse
// accepted outside RUN launches a 32-iteration run; done pulses for one cycle
// when quotient/remainder are loaded. A zero divisor skips RUN entirely.
//   i_clk, i_rst         : clock, asynchronous active-high reset
//   i_start              : request pulse, ignored while busy
//   i_dividend/i_divisor : operands, sampled on the accepting edge
//   i_is_signed          : signed select (only when DIV_SIGNED_EN is defined)
//   o_busy               : high in RUN
//   o_done               : one-cycle completion pulse (DONE state)
//   o_quotient/o_remainder/o_div_by_zero : registered results
// Optional feature macro: DIV_SIGNED_EN (adds i_is_signed and sign fix-up).
// -----------------------------------------------------------------------------
module seq_divider_32_bit
  import kgp_risc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
`ifdef DIV_SIGNED_EN
  input  logic             i_is_signed,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CNT_W = $clog2(DIV_ITERS);

  div_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q, r_neg_r;

  logic             w_accept, w_dvs_zero, w_last;
  logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
  logic             w_neg_q, w_neg_r;
  logic [WIDTH-1:0] w_sub_a, w_trial, w_rem_nxt, w_quo_nxt;
  logic             w_c_out, w_borrow;

  assign w_accept   = i_start && (r_state != RUN);
  assign w_dvs_zero = (i_divisor == '0);
  assign w_last     = (r_cnt == CNT_W'(DIV_ITERS - 1));

`ifdef DIV_SIGNED_EN
  // Signed operands run through the unsigned core as magnitudes; the sign
  // fix-up is remembered here and applied when the result is loaded.
  assign w_dvd_mag = i_is_signed ? abs32(i_dividend) : i_dividend;
  assign w_dvs_mag = i_is_signed ? abs32(i_divisor)  : i_divisor;
  assign w_neg_q   = i_is_signed && (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
  assign w_neg_r   = i_is_signed && i_dividend[WIDTH-1];
`else
  assign w_dvd_mag = i_dividend;
  assign w_dvs_mag = i_divisor;
  assign w_neg_q   = 1'b0;
  assign w_neg_r   = 1'b0;
`endif

  // Shifted partial remainder is really 33 bits: its top bit is r_rem's MSB.
  // If that bit is set the value exceeds any 32-bit divisor, so there is no
  // borrow and the low 32 bits of the difference are the exact new remainder.
  assign w_sub_a = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};

  subtractor_32_bit #(.WIDTH(WIDTH)) u_trial_sub (
    .i_a     (w_sub_a),
    .i_b     (r_dvs),
    .o_diff  (w_trial),
    .o_c_out (w_c_out)
  );

  assign w_borrow  = ~w_c_out & ~r_rem[WIDTH-1];
  assign w_rem_nxt = w_borrow ? w_sub_a : w_trial;
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_borrow};

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) w_state_nxt = w_dvs_zero ? DONE : RUN;
        else          w_state_nxt = IDLE;
      end
      RUN:     if (w_last) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvs         <= '0;
      r_cnt         <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_dvs         <= w_dvs_mag;
      r_neg_q       <= w_neg_q;
      r_neg_r       <= w_neg_r;
      o_div_by_zero <= w_dvs_zero;
      if (w_dvs_zero) begin
        // Raw dividend, regardless of signedness
        o_quotient  <= DIV_ZERO_QUOT;
        o_remainder <= i_dividend;
      end else begin
        r_rem <= '0;
        r_quo <= w_dvd_mag;
        r_cnt <= '0;
      end
    end else if (r_state == RUN) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        o_quotient  <= r_neg_q ? ('0 - w_quo_nxt) : w_quo_nxt;
        o_remainder <= r_neg_r ? ('0 - w_rem_nxt) : w_rem_nxt;
      end
    end
  end

  assign o_busy = (r_state == RUN);
  assign o_done = (r_state == DONE);

endmodule

// File: tb/tb_seq_divider_32_bit.sv
module tb_seq_divider_32_bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        is_signed;
  logic        busy, done, dbz;
  logic [31:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_divider_32_bit #(.WIDTH(32)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .i_is_signed   (is_signed),
`endif
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (dbz)
  );

  // Reference model: plain arithmetic on the operand values.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb;
    dz = (b == 32'd0);
    if (dz) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endtask

  // Present a request for one edge (E0), then scramble the operand inputs.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Called just after E0; lat = edges from E0 up to the edge that raised done.
  task automatic wait_done(output int lat, output int bcnt);
    int n;
    n = 0;
    bcnt = 0;
    while (!done && n < 60) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      n++;
    end
    lat = n + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", dbz); end
    n_checks++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL reset_q: got %h want 0", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL reset_r: got %h want 0", remainder); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_basic();
    int lat, bc;
    launch(32'd100, 32'd7, 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_e0: got %b want 1", busy); end
    wait_done(lat, bc);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL basic_lat: got %0d want 33", lat); end
    n_checks++; if (bc != 32) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 32", bc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done: got %b want 0", busy); end
    n_checks++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL basic_q: got %h want %h", quotient, 32'd14); end
    n_checks++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL basic_r: got %h want %h", remainder, 32'd2); end
    n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b want 0", dbz); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    n_checks++; if (quotient !== 32'd14 || remainder !== 32'd2) begin n_fail++; $display("FAIL basic_hold: got %h/%h want 0000000e/00000002", quotient, remainder); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    launch(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done(lat, bc);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL b2b_lat1: got %0d want 33", lat); end
    n_checks++; if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd0) begin n_fail++; $display("FAIL b2b_res1: got %h/%h want ffffffff/00000000", quotient, remainder); end
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
    wait_done(lat, bc);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL b2b_lat2: got %0d want 33", lat); end
    n_checks++; if (quotient !== 32'd1 || remainder !== 32'd0) begin n_fail++; $display("FAIL b2b_res2: got %h/%h want 00000001/00000000", quotient, remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int lat, bc;
    launch(32'd12345, 32'd0, 1'b0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dz_busy: got %b want 0", busy); end
    wait_done(lat, bc);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL dz_lat: got %0d want 1", lat); end
    n_checks++; if (quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_q: got %h want ffffffff", quotient); end
    n_checks++; if (remainder !== 32'd12345) begin n_fail++; $display("FAIL dz_r: got %h want %h", remainder, 32'd12345); end
    n_checks++; if (dbz !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", dbz); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0 || dbz !== 1'b1) begin n_fail++; $display("FAIL dz_after: got done=%b busy=%b dbz=%b want 0/0/1", done, busy, dbz); end
  endtask

  task automatic test_start_ignored();
    int lat, bc;
    launch(32'd50, 32'd5, 1'b0);
    n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL ign_dbz_clear: got %b want 0", dbz); end
    repeat (9) begin @(posedge clk); #1; end
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc);
    n_checks++; if (lat + 10 != 33) begin n_fail++; $display("FAIL ign_lat: got %0d want 33", lat + 10); end
    n_checks++; if (quotient !== 32'd10 || remainder !== 32'd0) begin n_fail++; $display("FAIL ign_res: got %h/%h want 0000000a/00000000", quotient, remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun();
    int lat, bc, seen;
    launch(32'd1000, 32'd3, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstrun_ctl: got busy=%b done=%b want 0/0", busy, done); end
    n_checks++; if (quotient !== 32'd0 || remainder !== 32'd0 || dbz !== 1'b0) begin n_fail++; $display("FAIL rstrun_out: got %h/%h/%b want 0/0/0", quotient, remainder, dbz); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) seen++; end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rstrun_no_done: got %0d active cycles want 0", seen); end
    launch(32'd1000, 32'd3, 1'b0);
    wait_done(lat, bc);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL rstrun_lat: got %0d want 33", lat); end
    n_checks++; if (quotient !== 32'd333 || remainder !== 32'd1) begin n_fail++; $display("FAIL rstrun_res: got %h/%h want 0000014d/00000001", quotient, remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_random(input logic allow_signed);
    int lat, bc;
    logic [31:0] a, b, eq, er;
    logic        s, edz;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = (i % 8 == 2) ? 32'd0 : (a >> $urandom_range(1, 31));
        default: b = {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, 16'($urandom)};
      endcase
      s = allow_signed && ($urandom_range(0, 1) == 1);
      ref_div(a, b, s, eq, er, edz);
      launch(a, b, s);
      wait_done(lat, bc);
      n_checks++;
      if (quotient !== eq || remainder !== er || dbz !== edz || lat != (edz ? 1 : 33)) begin
        n_fail++;
        $display("FAIL rand_%0d a=%h b=%h s=%b: got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=%0d",
                 i, a, b, s, quotient, remainder, dbz, lat, eq, er, edz, edz ? 1 : 33);
      end
      // Half the time restart in the DONE cycle, otherwise idle a few cycles
      if (i % 2 == 1) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    int lat, bc;
    launch(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(lat, bc);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL sgn_lat: got %0d want 33", lat); end
    n_checks++; if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sgn_m7_2: got %h/%h want fffffffd/ffffffff", quotient, remainder); end
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(lat, bc);
    n_checks++; if (quotient !== 32'h8000_0000 || remainder !== 32'd0) begin n_fail++; $display("FAIL sgn_ovf: got %h/%h want 80000000/00000000", quotient, remainder); end
    launch(32'hFFFF_FFF9, 32'd0, 1'b1);
    wait_done(lat, bc);
    n_checks++; if (lat != 1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'hFFFF_FFF9 || dbz !== 1'b1) begin n_fail++; $display("FAIL sgn_dz: got lat=%0d %h/%h/%b want 1 ffffffff/fffffff9/1", lat, quotient, remainder, dbz); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_start_ignored();
    test_reset_midrun();
    test_random(1'b0);
`ifdef DIV_SIGNED_EN
    test_signed();
    test_random(1'b1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
